mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Byte-serial load/store engine that executes the memory operations decoded by the control unit. It accepts one load or store request from the MEM stage, with a size (word/half/byte) and a sign-extension flag. It performs the access over an 8-bit request/acknowledge memory port, one byte per handshake, and returns assembled, extended load data. While an access is in flight it holds `busy` high so the pipeline stalls.

## Interface
- `ADDR_W`, 32, byte-address width of both the request address and the memory port.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present this cycle; sampled only when `req_ready`=1.
- `req_ready`  out  1  unit idle and able to accept a request.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `size`  in  2  00 word, 11 half, 01 byte, 10 reserved.
- `sign_ext`  in  1  loads only: 1 sign-extends byte/half, 0 zero-extends.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data; the low bytes are used for half/byte.
- `busy`  out  1  high whenever the state is not IDLE; this is the stall to the pipeline.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned, reserved size, or both read and write set.
- `rdata`  out  32  load result; updated only on a successful load `done`, held otherwise.
- `mem_req`  out  1  byte access request to memory.
- `mem_we`  out  1  1 = byte write, 0 = byte read; valid with `mem_req`.
- `mem_addr`  out  ADDR_W  byte address; valid with `mem_req`.
- `mem_wdata`  out  8  write byte; valid with `mem_req` and `mem_we`.
- `mem_rdata`  in  8  read byte; sampled in the cycle `mem_ack`=1.
- `mem_ack`  in  1  memory completes the current byte this cycle; may be asserted in the same cycle as `mem_req`.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ACCESS: `mem_req`=1.
  - DONE: `done`=1.
- Byte count n: 4 for word, 2 for half, 1 for byte.
- Byte order is little-endian. Byte k lives at `addr`+k and maps to data bits [8k+7:8k].
- IDLE, `req_valid`=1, neither `mem_read` nor `mem_write`: request is ignored and the state stays IDLE.
- IDLE, `req_valid`=1, exactly one of `mem_read`/`mem_write`, aligned, legal size:
  - latch addr, wdata, size, sign_ext and direction;
  - clear byte index to 0;
  - go to ACCESS.
- IDLE, `req_valid`=1, error case: go directly to DONE with `err`=1. No memory access is made and `rdata` is unchanged. Error cases are:
  - both `mem_read` and `mem_write` set;
  - size=10;
  - half with addr[0]≠0;
  - word with addr[1:0]≠0.
- ACCESS:
  - `mem_addr` = latched addr + index; `mem_we` = store; `mem_wdata` = latched wdata byte[index].
  - On `mem_ack`, a load captures `mem_rdata` into byte[index] of an assembly register.
  - On `mem_ack`, if index = n−1, go to DONE; otherwise increment index and stay in ACCESS.
  - Without `mem_ack`, all `mem_*` outputs hold stable.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
  - On a successful load, `rdata` loads the assembled value at the DONE-entry edge.
  - Byte/half loads are extended from bit 7/15 when `sign_ext`=1, otherwise zero-extended.
  - On a store, `rdata` is unchanged.
- `err`=0 on every non-error completion. `err` is meaningful only while `done`=1 and reads 0 otherwise.
- Reset mid-operation: immediate return to IDLE and `mem_req` drops asynchronously. Bytes already written stay in memory; there is no rollback and no `done`.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `req_ready`, `busy`, `done`, `err` and the `mem_*` outputs are decoded from registered state only; there is no combinational path from any input.
- Latency with zero-wait memory (ack in the same cycle as req): request accepted at edge 0, n ACCESS cycles, `done` in cycle n+1. Word = 5 cycles, half = 3, byte = 2.
- Each wait cycle (req high, ack low) adds exactly one cycle.
- Error latency: `done`/`err` in the cycle after acceptance.
- `busy` is high from the cycle after acceptance through the DONE cycle inclusive. The next request can be accepted in the cycle after DONE.

## Test plan
- Load word, zero-wait: addr=0x100, memory bytes 0x11,0x22,0x33,0x44 → `mem_addr` 0x100..0x103, `done` in cycle 5, `rdata`=0x44332211, `err`=0.
- Store half with 2 wait cycles per byte: addr=0x202, wdata=0xDEADBEEF → writes 0xEF@0x202 and 0xBE@0x203, each held stable 3 cycles; `done` in cycle 7; `rdata` unchanged.
- Signed vs unsigned byte load: byte 0x80 at 0x7 → `sign_ext`=1 gives `rdata`=0xFFFFFF80; `sign_ext`=0 gives 0x00000080. Half 0x8001 with sign gives 0xFFFF8001.
- Errors: word at 0x101, half at 0x3, size=10, or read+write together → `done`=`err`=1 in cycle 1, `mem_req` never asserts, `rdata` unchanged.
- Back-to-back: a store word followed immediately by a load word to the same address → load returns the stored value. `req_ready` is low for all of the first access, and the second request is accepted the cycle after the first `done`.
- Reset during the third byte of a word store → `mem_req`=0 and state IDLE without a clock edge. Bytes 0–1 remain in memory, no `done`, and the next request proceeds normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle for mem_access_unit: pipeline request side, byte-serial memory port and FSM debug view.
// Request handshake: a request transfers on a rising edge where req_valid=1 and req_ready=1.
// Memory handshake: a byte transfers on a rising edge where mem_req=1 and mem_ack=1.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic [1:0]        dbg_state;

    modport slave (
        input  req_valid, mem_read, mem_write, size, sign_ext, addr, wdata,
               mem_rdata, mem_ack,
        output req_ready, busy, done, err, rdata,
               mem_req, mem_we, mem_addr, mem_wdata, dbg_state
    );

    modport master (
        output req_valid, mem_read, mem_write, size, sign_ext, addr, wdata,
               mem_rdata, mem_ack,
        input  req_ready, busy, done, err, rdata,
               mem_req, mem_we, mem_addr, mem_wdata, dbg_state
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-serial load/store engine: one request in, 1/2/4 byte handshakes on the memory port,
// assembled and extended load data out. Status and memory outputs decode registered state only.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACCESS = 2'b01;
    localparam logic [1:0] S_DONE   = 2'b10;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b10;
    localparam logic [1:0] SZ_HALF = 2'b11;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       rdata_q;
    logic [1:0]        size_q;
    logic [1:0]        idx;
    logic              sext_q;
    logic              we_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [1:0]        last_idx;
    logic [31:0]       asm_next;
    logic [31:0]       load_val;
    logic              in_access;

    assign accept = (state == S_IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);

    always_comb begin
        req_err = 1'b0;
        if (bus.mem_read && bus.mem_write) begin
            req_err = 1'b1;
        end else begin
            case (bus.size)
                SZ_RSVD: req_err = 1'b1;
                SZ_HALF: req_err = bus.addr[0];
                SZ_WORD: req_err = (bus.addr[1:0] != 2'b00);
                default: req_err = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (size_q)
            SZ_WORD: last_idx = 2'd3;
            SZ_HALF: last_idx = 2'd1;
            default: last_idx = 2'd0;
        endcase
    end

    // Assembly value including the byte arriving this cycle, so rdata can load on the final ack.
    always_comb begin
        asm_next = asm_q;
        asm_next[{idx, 3'b000} +: 8] = bus.mem_rdata;
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: load_val = sext_q ? {{24{asm_next[7]}}, asm_next[7:0]}
                                       : {24'h0, asm_next[7:0]};
            SZ_HALF: load_val = sext_q ? {{16{asm_next[15]}}, asm_next[15:0]}
                                       : {16'h0, asm_next[15:0]};
            default: load_val = asm_next;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            size_q  <= SZ_WORD;
            idx     <= '0;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            addr_q  <= bus.addr;
                            wdata_q <= bus.wdata;
                            size_q  <= bus.size;
                            sext_q  <= bus.sign_ext;
                            we_q    <= bus.mem_write;
                            idx     <= '0;
                            state   <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_ack) begin
                        if (!we_q) asm_q <= asm_next;
                        if (idx == last_idx) begin
                            if (!we_q) rdata_q <= load_val;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory outputs are forced to zero outside ACCESS so idle and reset values are clean.
    assign in_access     = (state == S_ACCESS);
    assign bus.mem_req   = in_access;
    assign bus.mem_we    = in_access && we_q;
    assign bus.mem_addr  = in_access ? (addr_q + ADDR_W'(idx)) : '0;
    assign bus.mem_wdata = (in_access && we_q) ? wdata_q[{idx, 3'b000} +: 8] : 8'h00;

    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = (state == S_DONE) && err_q;
    assign bus.rdata     = rdata_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand sequences for waits,
// back-to-back requests and reset in mid-access.
module tb_mem_access_unit;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) bus();
  mem_access_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- memory model ----------------
  logic [7:0] mem [0:4095];
  int wait_n = 0;
  int wait_cnt;
  assign bus.mem_ack   = bus.mem_req && (wait_cnt == wait_n);
  assign bus.mem_rdata = mem[bus.mem_addr[11:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
    end else begin
      if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_addr[$];
  logic [7:0]  log_wd[$];
  logic        log_we[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Returns at the negedge of the done cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int wn,
                        output int cyc, output int idle_waits, output logic saw_req,
                        output logic stall_gap);
    logic rdy;
    wait_n = wn;
    bus.mem_read = rd; bus.mem_write = wr; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = wd; bus.req_valid = 1'b1;
    idle_waits = 0;
    forever begin
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy || idle_waits > 50) break;
      idle_waits++;
      @(negedge clk);
    end
    cyc = 0; saw_req = 1'b0; stall_gap = 1'b0;
    log_addr.delete(); log_wd.delete(); log_we.delete();
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      cyc++;
      if (bus.mem_req) begin
        log_addr.push_back(bus.mem_addr);
        log_wd.push_back(bus.mem_wdata);
        log_we.push_back(bus.mem_we);
        saw_req = 1'b1;
      end
      if (!bus.busy || bus.req_ready) stall_gap = 1'b1;
    end while (!bus.done && cyc < 200);
    if (!bus.done) begin
      total++; bad++;
      $display("FAIL timeout: no done after %0d cycles", cyc);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waitn;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cyc, iw;
    logic sr, sg;
    string nm;

    // memory preload
    for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    mem[12'h100] <= 8'h11; mem[12'h101] <= 8'h22; mem[12'h102] <= 8'h33; mem[12'h103] <= 8'h44;
    mem[12'h007] <= 8'h80;
    mem[12'h010] <= 8'h01; mem[12'h011] <= 8'h80;
    mem[12'h020] <= 8'h7F;

    //          rd    wr    size   sx    addr        wdata         wait rdata         err   cyc
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        0, 32'h44332211, 1'b0, 5};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h007, 32'h0,        0, 32'hFFFFFF80, 1'b0, 2};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h007, 32'h0,        0, 32'h00000080, 1'b0, 2};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 1'b1, 32'h010, 32'h0,        0, 32'hFFFF8001, 1'b0, 3};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h010, 32'h0,        0, 32'h00008001, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h020, 32'h0,        0, 32'h0000007F, 1'b0, 2};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        0, 32'h0000007F, 1'b1, 1};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h003, 32'h0,        0, 32'h0000007F, 1'b1, 1};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        0, 32'h0000007F, 1'b1, 1};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h000, 32'h0,        0, 32'h0000007F, 1'b1, 1};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h300, 32'hA1B2C3D4, 0, 32'h0000007F, 1'b0, 5};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h300, 32'h0,        0, 32'hA1B2C3D4, 1'b0, 5};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        1, 32'h44332211, 1'b0, 9};
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_rdata);

    // reset state
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b00;
    bus.sign_ext = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_done",      32'(bus.done), 32'd0);
    check("rst_err",       32'(bus.err), 32'd0);
    check("rst_rdata",     bus.rdata, 32'h0);
    check("rst_mem_req",   32'(bus.mem_req), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_state",     32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    foreach (vecs[i]) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].sext, vecs[i].addr,
             vecs[i].wdata, vecs[i].waitn, cyc, iw, sr, sg);
      nm = $sformatf("v%0d", i);
      check({nm, "_cycles"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      check({nm, "_err"}, 32'(bus.err), 32'(vecs[i].exp_err));
      check({nm, "_rdata"}, bus.rdata, exp_q.pop_front());
      check({nm, "_mem_req_seen"}, 32'(sr), 32'(!vecs[i].exp_err));
      check({nm, "_stall_gap"}, 32'(sg), 32'd0);
      @(negedge clk);
      check({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({nm, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    end

    // word load address sequence, zero-wait
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, cyc, iw, sr, sg);
    check("lw_log_len", 32'(log_addr.size()), 32'd4);
    for (int k = 0; k < log_addr.size(); k++) begin
      check($sformatf("lw_addr%0d", k), log_addr[k], 32'h100 + 32'(k));
      check($sformatf("lw_we%0d", k), 32'(log_we[k]), 32'd0);
    end
    @(negedge clk);

    // store half, 2 wait cycles per byte: each byte held 3 cycles
    do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h202, 32'hDEADBEEF, 2, cyc, iw, sr, sg);
    check("sh_cycles", 32'(cyc), 32'd7);
    check("sh_log_len", 32'(log_addr.size()), 32'd6);
    for (int k = 0; k < log_addr.size(); k++) begin
      check($sformatf("sh_addr%0d", k), log_addr[k], (k < 3) ? 32'h202 : 32'h203);
      check($sformatf("sh_wd%0d", k), 32'(log_wd[k]), (k < 3) ? 32'hEF : 32'hBE);
      check($sformatf("sh_we%0d", k), 32'(log_we[k]), 32'd1);
    end
    check("sh_rdata", bus.rdata, 32'h44332211);
    @(negedge clk);
    check("sh_mem202", 32'(mem[12'h202]), 32'hEF);
    check("sh_mem203", 32'(mem[12'h203]), 32'hBE);

    // back-to-back store word then load word
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h500, 32'h0BADF00D, 0, cyc, iw, sr, sg);
    check("b2b_st_stall_gap", 32'(sg), 32'd0);
    check("b2b_st_cycles", 32'(cyc), 32'd5);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 0, cyc, iw, sr, sg);
    check("b2b_ld_idle_waits", 32'(iw), 32'd1);
    check("b2b_ld_cycles", 32'(cyc), 32'd5);
    check("b2b_ld_rdata", bus.rdata, 32'h0BADF00D);
    @(negedge clk);

    // request with neither read nor write is ignored
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ign_state", 32'(bus.dbg_state), 32'd0);
      check("ign_done", 32'(bus.done), 32'd0);
    end
    bus.req_valid = 1'b0;

    // reset during third byte of a word store
    wait_n = 0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.size = 2'b00; bus.addr = 32'h400;
    bus.wdata = 32'h55667788; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rm_third_addr", bus.mem_addr, 32'h402);
    rst = 1'b1;
    #1;
    check("rm_mem_req", 32'(bus.mem_req), 32'd0);
    check("rm_state", 32'(bus.dbg_state), 32'd0);
    check("rm_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("rm_no_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    check("rm_mem400", 32'(mem[12'h400]), 32'h88);
    check("rm_mem401", 32'(mem[12'h401]), 32'h77);
    check("rm_mem402", 32'(mem[12'h402]), 32'h00);
    @(negedge clk);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 0, cyc, iw, sr, sg);
    check("rm_next_cycles", 32'(cyc), 32'd2);
    check("rm_next_rdata", bus.rdata, 32'h00000077);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
